// File: rtl/trace_buf_pkg.sv
// Shared encodings and helpers for the trace-buffer capture controller.
package trace_buf_pkg;

  // Capture mode as presented on the mode input; MODE_RSVD behaves like MODE_CONT
  typedef enum logic [1:0] {
    MODE_CONT    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_TRIG    = 2'd2,
    MODE_RSVD    = 2'd3
  } cap_mode_e;

  // Control FSM state, also exported on the state output
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } cap_state_e;

  // Number of BRAM entries addressed by an address of the given width
  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/trace_buf_wr_ptr.sv
// Write pointer for the trace buffer: owns the next-write address, the
// registered port-A address/enable and the sticky wrap flag.
module trace_buf_wr_ptr
  import trace_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic [ADDR_WIDTH-1:0] last,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic                  wrapped
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(depth_of(ADDR_WIDTH) - 1);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wrapped_q, wrapped_d;

  // Pointer advances on every accepted sample and rewinds to zero on arm; the
  // port-A address only moves when a write actually happens
  always_comb begin
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
    wrapped_d = wrapped_q;
    if (clear) begin
      ptr_d     = '0;
      wrapped_d = 1'b0;
    end else if (advance) begin
      ptr_d     = ptr_q + ADDR_WIDTH'(1);
      wr_addr_d = ptr_q;
      wr_en_d   = 1'b1;
      if (ptr_q == LAST_ADDR) begin
        wrapped_d = 1'b1;
      end
    end
  end

  // Pointer and port-A registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q     <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign ptr     = ptr_q;
  assign last    = ptr_q - ADDR_WIDTH'(1);
  assign wr_addr = wr_addr_q;
  assign wr_en   = wr_en_q;
  assign wrapped = wrapped_q;

endmodule

// File: rtl/trace_buf_capture_ctrl.sv
// Trace-buffer capture controller: arm/stop FSM with continuous, one-shot and
// triggered capture modes, trigger latch, post-trigger counter and a port-B
// read address expressed as a look-back from the newest sample.
module trace_buf_capture_ctrl
  import trace_buf_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int OFFSET_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sample_en,
  input  logic [1:0]              mode,
  input  logic                    arm,
  input  logic                    stop,
  input  logic                    trigger,
  input  logic [ADDR_WIDTH-1:0]   post_trig_len,
  input  logic [OFFSET_WIDTH-1:0] rd_offset,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [1:0]              state,
  output logic                    wrapped,
  output logic                    triggered,
  output logic [ADDR_WIDTH-1:0]   trig_addr,
  output logic                    done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(depth_of(ADDR_WIDTH) - 1);

  cap_state_e            state_q, state_d;
  cap_mode_e             mode_q, mode_d;
  logic                  triggered_q, triggered_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH:0]   post_cnt_q, post_cnt_d, post_cnt_inc;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] last;
  logic                  accept;
  logic                  arm_go;
  logic                  trig_hit;

  // stop overrides arm, and both pulses suppress a coincident sample so the
  // pointer is never advanced while it is being reset or frozen
  assign arm_go   = arm && !stop;
  assign accept   = sample_en && !arm && !stop
                    && ((state_q == ST_RUN) || (state_q == ST_POST));
  assign trig_hit = trigger && !arm && !stop
                    && (state_q == ST_RUN) && (mode_q == MODE_TRIG);

  assign post_cnt_inc = post_cnt_q + (ADDR_WIDTH+1)'(accept);

  trace_buf_wr_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (arm_go),
    .advance (accept),
    .ptr     (ptr),
    .last    (last),
    .wr_addr (wr_addr),
    .wr_en   (wr_en),
    .wrapped (wrapped)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stop and arm act from any state, capture end depends on mode
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if ((mode_q == MODE_ONESHOT) && accept && (ptr == LAST_ADDR)) begin
            state_d = ST_DONE;
          end else if (trig_hit) begin
            state_d = (post_trig_len == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (post_cnt_inc >= {1'b0, post_trig_len}) begin
            state_d = ST_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output and datapath next values: mode latch, trigger capture, post counter, read address
  always_comb begin
    mode_d      = mode_q;
    triggered_d = triggered_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;
    done_d      = (state_d == ST_DONE);
    rd_addr_d   = last - rd_offset[ADDR_WIDTH-1:0];
    if (arm_go) begin
      mode_d      = cap_mode_e'(mode);
      triggered_d = 1'b0;
      trig_addr_d = '0;
      post_cnt_d  = '0;
    end else begin
      if (trig_hit) begin
        triggered_d = 1'b1;
        trig_addr_d = sample_en ? ptr : last;
      end
      if (state_q == ST_POST) begin
        post_cnt_d = post_cnt_inc;
      end
    end
  end

  // Registers behind every status and read-address output
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q      <= MODE_CONT;
      triggered_q <= 1'b0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      rd_addr_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      triggered_q <= triggered_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      rd_addr_q   <= rd_addr_d;
      done_q      <= done_d;
    end
  end

  // Only the low address bits of the offset register select a look-back distance
  generate
    if (OFFSET_WIDTH > ADDR_WIDTH) begin : g_offset_hi
      logic unused_offset_hi;
      assign unused_offset_hi = ^rd_offset[OFFSET_WIDTH-1:ADDR_WIDTH];
    end
  endgenerate

  assign state     = state_q;
  assign triggered = triggered_q;
  assign trig_addr = trig_addr_q;
  assign rd_addr   = rd_addr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_trace_buf_capture_ctrl.sv
// Directed bench for trace_buf_capture_ctrl with a 16-entry buffer.
module tb_trace_buf_capture_ctrl;

  localparam int AW = 4;
  localparam int OW = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] M_CONT    = 2'd0;
  localparam logic [1:0] M_ONESHOT = 2'd1;
  localparam logic [1:0] M_TRIG    = 2'd2;

  logic          clk;
  logic          rstn;
  logic          sample_en;
  logic [1:0]    mode;
  logic          arm;
  logic          stop;
  logic          trigger;
  logic [AW-1:0] post_trig_len;
  logic [OW-1:0] rd_offset;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    state;
  logic          wrapped;
  logic          triggered;
  logic [AW-1:0] trig_addr;
  logic          done;

  int errors;
  int checks;
  int writes;

  trace_buf_capture_ctrl #(
    .ADDR_WIDTH   (AW),
    .OFFSET_WIDTH (OW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .sample_en     (sample_en),
    .mode          (mode),
    .arm           (arm),
    .stop          (stop),
    .trigger       (trigger),
    .post_trig_len (post_trig_len),
    .rd_offset     (rd_offset),
    .wr_addr       (wr_addr),
    .wr_en         (wr_en),
    .rd_addr       (rd_addr),
    .state         (state),
    .wrapped       (wrapped),
    .triggered     (triggered),
    .trig_addr     (trig_addr),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of pulses, let the edge take them, then sample #1 after it
  task automatic applyStimulus(input logic s, input logic a, input logic p, input logic t);
    sample_en = s;
    arm       = a;
    stop      = p;
    trigger   = t;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    arm       = 1'b0;
    stop      = 1'b0;
    trigger   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rstn          = 1'b0;
    sample_en     = 1'b0;
    mode          = M_CONT;
    arm           = 1'b0;
    stop          = 1'b0;
    trigger       = 1'b0;
    post_trig_len = '0;
    rd_offset     = '0;

    // Reset values
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("rst_wr_en", 32'(wr_en), 0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 0);
    checkOutput("rst_state", 32'(state), 32'(S_IDLE));
    checkOutput("rst_wrapped", 32'(wrapped), 0);
    checkOutput("rst_triggered", 32'(triggered), 0);
    checkOutput("rst_trig_addr", 32'(trig_addr), 0);
    checkOutput("rst_done", 32'(done), 0);
    rstn = 1'b1;

    // Sample in IDLE is not written
    applyStimulus(1, 0, 0, 0);
    checkOutput("idle_wr_en", 32'(wr_en), 0);

    // Continuous ring: 20 strobes wrap through 0..15 then 0..3
    mode = M_CONT;
    applyStimulus(0, 1, 0, 0);
    checkOutput("cont_arm_state", 32'(state), 32'(S_RUN));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("cont_wr_en", 32'(wr_en), 1);
      checkOutput("cont_wr_addr", 32'(wr_addr), 32'(i % 16));
      checkOutput("cont_wrapped", 32'(wrapped), (i >= 15) ? 1 : 0);
      checkOutput("cont_state", 32'(state), 32'(S_RUN));
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("cont_gap_wr_en", 32'(wr_en), 0);
    checkOutput("cont_gap_wr_addr", 32'(wr_addr), 3);

    // Look-back read address after 10 writes
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);
    rd_offset = 32'd0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("rd_off0", 32'(rd_addr), 9);
    rd_offset = 32'd12;
    applyStimulus(0, 0, 0, 0);
    checkOutput("rd_off12", 32'(rd_addr), 13);
    rd_offset = 32'h0001_0003;
    applyStimulus(0, 0, 0, 0);
    checkOutput("rd_off_hi_ignored", 32'(rd_addr), 6);
    rd_offset = 32'd0;

    // One-shot: exactly 16 writes then DONE
    mode   = M_ONESHOT;
    writes = 0;
    applyStimulus(0, 1, 0, 0);
    checkOutput("os_wrapped_cleared", 32'(wrapped), 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 0);
      if (wr_en) writes++;
      if (i < 16) begin
        checkOutput("os_wr_en", 32'(wr_en), 1);
        checkOutput("os_wr_addr", 32'(wr_addr), 32'(i));
        checkOutput("os_done", 32'(done), (i == 15) ? 1 : 0);
        checkOutput("os_state", 32'(state), (i == 15) ? 32'(S_DONE) : 32'(S_RUN));
      end else begin
        checkOutput("os_late_wr_en", 32'(wr_en), 0);
        checkOutput("os_late_wr_addr", 32'(wr_addr), 15);
        checkOutput("os_late_done", 32'(done), 1);
      end
    end
    checkOutput("os_write_count", 32'(writes), 16);

    // Triggered, post length 3: trigger with strobe 6 lands at address 5
    mode          = M_TRIG;
    post_trig_len = 4'd3;
    applyStimulus(0, 1, 0, 0);
    checkOutput("trg_arm_state", 32'(state), 32'(S_RUN));
    checkOutput("trg_arm_done", 32'(done), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("trg_pre_triggered", 32'(triggered), 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("trg_hit_wr_addr", 32'(wr_addr), 5);
    checkOutput("trg_hit_triggered", 32'(triggered), 1);
    checkOutput("trg_hit_trig_addr", 32'(trig_addr), 5);
    checkOutput("trg_hit_state", 32'(state), 32'(S_POST));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("trg_post_wr_en", 32'(wr_en), 1);
      checkOutput("trg_post_wr_addr", 32'(wr_addr), 32'(6 + i));
      checkOutput("trg_post_state", 32'(state), (i == 2) ? 32'(S_DONE) : 32'(S_POST));
    end
    checkOutput("trg_done", 32'(done), 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("trg_after_wr_en", 32'(wr_en), 0);
    checkOutput("trg_after_wr_addr", 32'(wr_addr), 8);

    // Trigger without a strobe, post length 0: trig_addr is the newest sample
    post_trig_len = 4'd0;
    applyStimulus(0, 1, 0, 0);
    checkOutput("trg0_rearm_triggered", 32'(triggered), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("trg0_trig_addr", 32'(trig_addr), 2);
    checkOutput("trg0_state", 32'(state), 32'(S_DONE));
    checkOutput("trg0_done", 32'(done), 1);

    // CONT ignores trigger; arm with stop leaves the pointer untouched
    mode = M_CONT;
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("cont_trig_ignored", 32'(triggered), 0);
    checkOutput("cont_trig_state", 32'(state), 32'(S_RUN));
    applyStimulus(0, 1, 1, 0);
    checkOutput("armstop_state", 32'(state), 32'(S_IDLE));
    applyStimulus(0, 0, 0, 0);
    checkOutput("armstop_rd_addr", 32'(rd_addr), 3);
    checkOutput("armstop_wr_addr", 32'(wr_addr), 3);
    applyStimulus(1, 0, 0, 0);
    checkOutput("armstop_idle_wr_en", 32'(wr_en), 0);

    // Stop in the middle of the post-trigger phase keeps the trigger flags
    mode          = M_TRIG;
    post_trig_len = 4'd5;
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("stoppost_state_pre", 32'(state), 32'(S_POST));
    applyStimulus(0, 0, 1, 0);
    checkOutput("stoppost_state", 32'(state), 32'(S_IDLE));
    checkOutput("stoppost_triggered", 32'(triggered), 1);
    checkOutput("stoppost_trig_addr", 32'(trig_addr), 2);
    checkOutput("stoppost_done", 32'(done), 0);

    // Reset mid-run, then arm (with a coincident strobe) restarts at address 0
    mode = M_CONT;
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    rstn = 1'b0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("midrst_wr_addr", 32'(wr_addr), 0);
    checkOutput("midrst_wr_en", 32'(wr_en), 0);
    checkOutput("midrst_rd_addr", 32'(rd_addr), 0);
    checkOutput("midrst_state", 32'(state), 32'(S_IDLE));
    checkOutput("midrst_wrapped", 32'(wrapped), 0);
    checkOutput("midrst_done", 32'(done), 0);
    rstn = 1'b1;
    applyStimulus(1, 1, 0, 0);
    checkOutput("rearm_strobe_wr_en", 32'(wr_en), 0);
    checkOutput("rearm_state", 32'(state), 32'(S_RUN));
    applyStimulus(1, 0, 0, 0);
    checkOutput("rearm_wr_en", 32'(wr_en), 1);
    checkOutput("rearm_wr_addr", 32'(wr_addr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
